// File: rtl/ext_spike_router.sv
// ext_spike_router
//   Registered spike crossbar in front of the synapse array. Each synapse
//   row gets one output spike per cycle, chosen from (highest first): the
//   external stimulus spike for that row, the row's pending slot, then
//   neuron-column feedback spikes routed by a writable per-column table.
//   The second candidate is parked in a one-deep pending slot; any further
//   candidates are dropped and counted in a saturating drop counter.
//
// Ports
//   clk              system clock
//   reset            synchronous, active-low reset
//   nrn_spike_valid  [NUM_COLS]           one-cycle spike pulse per column
//   ext_valid        [NUM_SYNAPSE_ROWS]   external spike per row
//   ext_addr         [ROWS*ADDR_WIDTH]    external address, row r at [r*AW +: AW]
//   route_we         routing-table write strobe
//   route_col        column index to write (ignored if >= NUM_COLS)
//   route_mask       [NUM_SYNAPSE_ROWS]   rows receiving this column's spikes
//   route_addr       [ADDR_WIDTH]         address attached to routed spikes
//   row_valid        [NUM_SYNAPSE_ROWS]   registered spike pulse per row
//   row_addr         [ROWS*ADDR_WIDTH]    registered address, same packing
//   drop_count       [CNT_WIDTH]          saturating dropped-spike count
module ext_spike_router #(
  parameter int NUM_SYNAPSE_ROWS = 20,
  parameter int NUM_COLS         = 2,
  parameter int ADDR_WIDTH       = 6,
  parameter int CNT_WIDTH        = 16,
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_COLS-1:0]                    nrn_spike_valid,
  input  logic [NUM_SYNAPSE_ROWS-1:0]            ext_valid,
  input  logic [NUM_SYNAPSE_ROWS*ADDR_WIDTH-1:0] ext_addr,
  input  logic                                   route_we,
  input  logic [COL_W-1:0]                       route_col,
  input  logic [NUM_SYNAPSE_ROWS-1:0]            route_mask,
  input  logic [ADDR_WIDTH-1:0]                  route_addr,
  output logic [NUM_SYNAPSE_ROWS-1:0]            row_valid,
  output logic [NUM_SYNAPSE_ROWS*ADDR_WIDTH-1:0] row_addr,
  output logic [CNT_WIDTH-1:0]                   drop_count
);

  // Candidate slots per row: 0 = external, 1 = pending, 2.. = columns.
  localparam int NCAND = NUM_COLS + 2;
  localparam logic [COL_W:0] NUM_COLS_V = (COL_W+1)'(NUM_COLS);

  logic [NUM_SYNAPSE_ROWS-1:0]            tbl_mask [NUM_COLS];
  logic [ADDR_WIDTH-1:0]                  tbl_addr [NUM_COLS];

  logic [NUM_SYNAPSE_ROWS-1:0]            pend_valid;
  logic [NUM_SYNAPSE_ROWS*ADDR_WIDTH-1:0] pend_addr;

  logic [NUM_SYNAPSE_ROWS-1:0]            nxt_valid;
  logic [NUM_SYNAPSE_ROWS*ADDR_WIDTH-1:0] nxt_addr;
  logic [NUM_SYNAPSE_ROWS-1:0]            nxt_pend_valid;
  logic [NUM_SYNAPSE_ROWS*ADDR_WIDTH-1:0] nxt_pend_addr;
  logic [CNT_WIDTH-1:0]                   nxt_drop;

  logic                                   cand_v [NCAND];
  logic [ADDR_WIDTH-1:0]                  cand_a [NCAND];
  int unsigned                            cand_n;
  logic [31:0]                            drops;
  logic [CNT_WIDTH+31:0]                  drop_sum;

  // Per-row arbitration: walk candidates in priority order; first wins,
  // second is parked, the rest are dropped.
  always_comb begin
    nxt_valid      = '0;
    nxt_addr       = row_addr;
    nxt_pend_valid = '0;
    nxt_pend_addr  = pend_addr;
    drops          = '0;
    cand_n         = 0;
    for (int unsigned k = 0; k < NCAND; k++) begin
      cand_v[k] = 1'b0;
      cand_a[k] = '0;
    end

    for (int unsigned r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
      cand_v[0] = ext_valid[r];
      cand_a[0] = ext_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
      cand_v[1] = pend_valid[r];
      cand_a[1] = pend_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
      for (int unsigned c = 0; c < NUM_COLS; c++) begin
        cand_v[c+2] = nrn_spike_valid[c] & tbl_mask[c][r];
        cand_a[c+2] = tbl_addr[c];
      end

      cand_n = 0;
      for (int unsigned k = 0; k < NCAND; k++) begin
        if (cand_v[k]) begin
          if (cand_n == 0) begin
            nxt_valid[r]                           = 1'b1;
            nxt_addr[r*ADDR_WIDTH +: ADDR_WIDTH]   = cand_a[k];
          end else if (cand_n == 1) begin
            nxt_pend_valid[r]                         = 1'b1;
            nxt_pend_addr[r*ADDR_WIDTH +: ADDR_WIDTH] = cand_a[k];
          end else begin
            drops = drops + 32'd1;
          end
          cand_n = cand_n + 1;
        end
      end
    end

    // Widened add so a large per-cycle burst cannot wrap before saturation.
    drop_sum = {32'd0, drop_count} + {{CNT_WIDTH{1'b0}}, drops};
    if (drop_sum > {32'd0, {CNT_WIDTH{1'b1}}})
      nxt_drop = '1;
    else
      nxt_drop = drop_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_valid  <= '0;
      row_addr   <= '0;
      pend_valid <= '0;
      pend_addr  <= '0;
      drop_count <= '0;
      for (int unsigned c = 0; c < NUM_COLS; c++) begin
        tbl_mask[c] <= '0;
        tbl_addr[c] <= '0;
      end
    end else begin
      row_valid  <= nxt_valid;
      row_addr   <= nxt_addr;
      pend_valid <= nxt_pend_valid;
      pend_addr  <= nxt_pend_addr;
      drop_count <= nxt_drop;
      // Arbitration above reads the old table, so a write is seen next cycle.
      if (route_we && ({1'b0, route_col} < NUM_COLS_V)) begin
        tbl_mask[route_col] <= route_mask;
        tbl_addr[route_col] <= route_addr;
      end
    end
  end

endmodule

// File: tb/tb_ext_spike_router.sv
module tb_ext_spike_router;

  localparam int R  = 20;
  localparam int C  = 2;
  localparam int AW = 6;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [C-1:0]      nrn_spike_valid = '0;
  logic [R-1:0]      ext_valid = '0;
  logic [R*AW-1:0]   ext_addr = '0;
  logic              route_we = 1'b0;
  logic [0:0]        route_col = '0;
  logic [R-1:0]      route_mask = '0;
  logic [AW-1:0]     route_addr = '0;
  logic [R-1:0]      row_valid;
  logic [R*AW-1:0]   row_addr;
  logic [CW-1:0]     drop_count;
  logic [R-1:0]      row_valid4;
  logic [R*AW-1:0]   row_addr4;
  logic [3:0]        drop_count4;

  int errors = 0;
  int checks = 0;

  ext_spike_router #(.NUM_SYNAPSE_ROWS(R), .NUM_COLS(C), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .nrn_spike_valid(nrn_spike_valid),
    .ext_valid(ext_valid), .ext_addr(ext_addr), .route_we(route_we),
    .route_col(route_col), .route_mask(route_mask), .route_addr(route_addr),
    .row_valid(row_valid), .row_addr(row_addr), .drop_count(drop_count));

  ext_spike_router #(.NUM_SYNAPSE_ROWS(R), .NUM_COLS(C), .ADDR_WIDTH(AW), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .nrn_spike_valid(nrn_spike_valid),
    .ext_valid(ext_valid), .ext_addr(ext_addr), .route_we(route_we),
    .route_col(route_col), .route_mask(route_mask), .route_addr(route_addr),
    .row_valid(row_valid4), .row_addr(row_addr4), .drop_count(drop_count4));

  always #5 clk = ~clk;

  // Reference model: per row, gather candidate addresses into a list in
  // priority order; head goes out, next waits, the rest are dropped.
  bit [R-1:0]  m_valid;
  bit [AW-1:0] m_addr [R];
  bit          m_pv [R];
  bit [AW-1:0] m_pa [R];
  bit [R-1:0]  m_mask [C];
  bit [AW-1:0] m_taddr [C];
  longint      m_drops;

  function automatic logic [R*AW-1:0] exp_addr();
    logic [R*AW-1:0] v;
    for (int r = 0; r < R; r++) v[r*AW +: AW] = m_addr[r];
    return v;
  endfunction

  function automatic logic [CW-1:0] exp_drop();
    return (m_drops > 65535) ? 16'hFFFF : CW'(m_drops);
  endfunction

  function automatic logic [3:0] exp_drop4();
    return (m_drops > 15) ? 4'hF : 4'(m_drops);
  endfunction

  task automatic cycle();
    int q[$];
    @(posedge clk);
    if (!reset) begin
      m_valid = '0;
      m_drops = 0;
      for (int r = 0; r < R; r++) begin m_addr[r] = '0; m_pv[r] = 0; m_pa[r] = '0; end
      for (int c = 0; c < C; c++) begin m_mask[c] = '0; m_taddr[c] = '0; end
    end else begin
      for (int r = 0; r < R; r++) begin
        q.delete();
        if (ext_valid[r]) q.push_back(int'(ext_addr[r*AW +: AW]));
        if (m_pv[r]) q.push_back(int'(m_pa[r]));
        for (int c = 0; c < C; c++)
          if (nrn_spike_valid[c] && m_mask[c][r]) q.push_back(int'(m_taddr[c]));
        m_valid[r] = (q.size() > 0);
        if (q.size() > 0) m_addr[r] = AW'(q[0]);
        m_pv[r] = (q.size() > 1);
        if (q.size() > 1) m_pa[r] = AW'(q[1]);
        if (q.size() > 2) m_drops += q.size() - 2;
      end
      if (route_we && int'(route_col) < C) begin
        m_mask[route_col] = route_mask;
        m_taddr[route_col] = route_addr;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    nrn_spike_valid = '0;
    ext_valid = '0;
    route_we = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
  endtask

  task automatic write_route(input int col, input logic [R-1:0] mask, input logic [AW-1:0] addr);
    route_we = 1'b1;
    route_col = 1'(col);
    route_mask = mask;
    route_addr = addr;
    cycle();
    route_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ext_valid = '1;
    for (int r = 0; r < R; r++) ext_addr[r*AW +: AW] = AW'($urandom);
    repeat (3) cycle();
    checks++;
    if (row_valid !== '0) begin errors++; $display("FAIL reset_valid got=%h exp=0", row_valid); end
    checks++;
    if (drop_count !== '0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
    checks++;
    if (row_addr !== '0) begin errors++; $display("FAIL reset_addr got=%h exp=0", row_addr); end
    reset = 1'b1;
    cycle();
    checks++;
    if (row_valid !== {R{1'b1}}) begin errors++; $display("FAIL release_valid got=%h exp=%h", row_valid, {R{1'b1}}); end
    checks++;
    if (row_addr !== ext_addr) begin errors++; $display("FAIL release_addr got=%h exp=%h", row_addr, ext_addr); end
    idle_inputs();
    cycle();
  endtask

  task automatic test_passthrough();
    logic [AW-1:0] a;
    logic [R*AW-1:0] held;
    for (int r = 0; r < R; r++) begin
      idle_inputs();
      for (int k = 0; k < R; k++) ext_addr[k*AW +: AW] = AW'($urandom);
      if (r == 5) ext_addr[5*AW +: AW] = '0;
      a = ext_addr[r*AW +: AW];
      ext_valid[r] = 1'b1;
      cycle();
      idle_inputs();
      checks++;
      if (row_valid !== (R'(1) << r)) begin errors++; $display("FAIL pass_valid row=%0d got=%h exp=%h", r, row_valid, R'(1) << r); end
      checks++;
      if (row_addr[r*AW +: AW] !== a) begin errors++; $display("FAIL pass_addr row=%0d got=%h exp=%h", r, row_addr[r*AW +: AW], a); end
      checks++;
      if (row_addr !== exp_addr()) begin errors++; $display("FAIL pass_all_addr row=%0d got=%h exp=%h", r, row_addr, exp_addr()); end
      held = exp_addr();
      cycle();
      checks++;
      if (row_valid !== '0) begin errors++; $display("FAIL pass_pulse row=%0d got=%h exp=0", r, row_valid); end
      checks++;
      if (row_addr !== held) begin errors++; $display("FAIL pass_hold row=%0d got=%h exp=%h", r, row_addr, held); end
    end
  endtask

  task automatic test_routing();
    write_route(1, R'(1) << 3, 6'd3);
    nrn_spike_valid = 2'b10;
    cycle();
    idle_inputs();
    checks++;
    if (row_valid !== (R'(1) << 3)) begin errors++; $display("FAIL route_valid got=%h exp=%h", row_valid, R'(1) << 3); end
    checks++;
    if (row_addr[3*AW +: AW] !== 6'd3) begin errors++; $display("FAIL route_addr got=%h exp=3", row_addr[3*AW +: AW]); end
    cycle();
    checks++;
    if (row_valid !== '0) begin errors++; $display("FAIL route_pulse got=%h exp=0", row_valid); end

    write_route(1, '0, 6'd3);
    nrn_spike_valid = 2'b10;
    cycle();
    idle_inputs();
    checks++;
    if (row_valid !== '0) begin errors++; $display("FAIL route_mask0 got=%h exp=0", row_valid); end

    write_route(1, R'(1) << 3, 6'd3);
    route_we = 1'b1;
    route_col = 1'b1;
    route_mask = R'(1) << 7;
    route_addr = 6'd9;
    nrn_spike_valid = 2'b10;
    cycle();
    route_we = 1'b0;
    checks++;
    if (row_valid !== (R'(1) << 3) || row_addr[3*AW +: AW] !== 6'd3) begin
      errors++; $display("FAIL route_old_table got=%h/%h exp=%h/3", row_valid, row_addr[3*AW +: AW], R'(1) << 3);
    end
    cycle();
    idle_inputs();
    checks++;
    if (row_valid !== (R'(1) << 7) || row_addr[7*AW +: AW] !== 6'd9) begin
      errors++; $display("FAIL route_new_table got=%h/%h exp=%h/9", row_valid, row_addr[7*AW +: AW], R'(1) << 7);
    end
    write_route(1, '0, '0);
  endtask

  task automatic collide_setup();
    do_reset();
    write_route(0, R'(1), 6'd0);
    write_route(1, R'(1), 6'd2);
    ext_valid = R'(1);
    ext_addr[0 +: AW] = 6'h3F;
    nrn_spike_valid = 2'b11;
    cycle();
    idle_inputs();
  endtask

  task automatic test_collision();
    collide_setup();
    checks++;
    if (row_valid !== R'(1) || row_addr[0 +: AW] !== 6'h3F) begin
      errors++; $display("FAIL coll_first got=%h/%h exp=1/3f", row_valid, row_addr[0 +: AW]);
    end
    checks++;
    if (drop_count !== 16'd1) begin errors++; $display("FAIL coll_drop got=%0d exp=1", drop_count); end
    cycle();
    checks++;
    if (row_valid !== R'(1) || row_addr[0 +: AW] !== 6'h00) begin
      errors++; $display("FAIL coll_pending got=%h/%h exp=1/00", row_valid, row_addr[0 +: AW]);
    end
    cycle();
    checks++;
    if (row_valid !== '0 || drop_count !== 16'd1) begin
      errors++; $display("FAIL coll_after got=%h/%0d exp=0/1", row_valid, drop_count);
    end
  endtask

  task automatic test_preempt();
    logic [AW-1:0] a;
    collide_setup();
    checks++;
    if (row_addr[0 +: AW] !== 6'h3F) begin errors++; $display("FAIL pre_first got=%h exp=3f", row_addr[0 +: AW]); end
    for (int k = 0; k < 3; k++) begin
      a = AW'(6'h10 + k);
      ext_valid = R'(1);
      ext_addr[0 +: AW] = a;
      cycle();
      idle_inputs();
      checks++;
      if (row_valid !== R'(1) || row_addr[0 +: AW] !== a) begin
        errors++; $display("FAIL pre_ext k=%0d got=%h/%h exp=1/%h", k, row_valid, row_addr[0 +: AW], a);
      end
    end
    cycle();
    checks++;
    if (row_valid !== R'(1) || row_addr[0 +: AW] !== 6'h00) begin
      errors++; $display("FAIL pre_pending got=%h/%h exp=1/00", row_valid, row_addr[0 +: AW]);
    end
    checks++;
    if (drop_count !== 16'd1) begin errors++; $display("FAIL pre_drop got=%0d exp=1", drop_count); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ext_valid = R'($urandom & $urandom);
      for (int r = 0; r < R; r++) ext_addr[r*AW +: AW] = AW'($urandom);
      nrn_spike_valid = C'($urandom);
      route_we = ($urandom_range(0, 7) == 0);
      route_col = 1'($urandom);
      route_mask = R'($urandom);
      route_addr = AW'($urandom);
      cycle();
      checks++;
      if (row_valid !== m_valid) begin errors++; $display("FAIL rnd_valid i=%0d got=%h exp=%h", i, row_valid, m_valid); end
      checks++;
      if (row_addr !== exp_addr()) begin errors++; $display("FAIL rnd_addr i=%0d got=%h exp=%h", i, row_addr, exp_addr()); end
      checks++;
      if (drop_count !== exp_drop()) begin errors++; $display("FAIL rnd_drop i=%0d got=%0d exp=%0d", i, drop_count, exp_drop()); end
      checks++;
      if (drop_count4 !== exp_drop4()) begin errors++; $display("FAIL rnd_drop4 i=%0d got=%0d exp=%0d", i, drop_count4, exp_drop4()); end
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    write_route(0, '1, 6'd1);
    write_route(1, '1, 6'd2);
    ext_valid = '1;
    nrn_spike_valid = 2'b11;
    cycle();
    checks++;
    if (drop_count !== 16'd20) begin errors++; $display("FAIL sat_first got=%0d exp=20", drop_count); end
    checks++;
    if (drop_count4 !== 4'd15) begin errors++; $display("FAIL sat4_first got=%0d exp=15", drop_count4); end
    for (int i = 0; i < 1700; i++) begin
      cycle();
      checks++;
      if (drop_count !== exp_drop()) begin errors++; $display("FAIL sat_track i=%0d got=%0d exp=%0d", i, drop_count, exp_drop()); end
    end
    checks++;
    if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%0d exp=65535", drop_count); end
    checks++;
    if (drop_count4 !== 4'hF) begin errors++; $display("FAIL sat4_hold got=%0d exp=15", drop_count4); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_routing();
    test_collision();
    test_preempt();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
